// File: rtl/pipeline_latealu_pkg.sv
// Shared op codes, FSM states and helpers for the late-stage ALU.
package pipeline_latealu_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned OP_W      = 6;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned DIV_STEPS = 32;

    localparam logic [OP_W-1:0] OP_SRL   = 6'h02;
    localparam logic [OP_W-1:0] OP_SRA   = 6'h03;
    localparam logic [OP_W-1:0] OP_MULT  = 6'h04;
    localparam logic [OP_W-1:0] OP_MTHI  = 6'h05;
    localparam logic [OP_W-1:0] OP_MTLO  = 6'h06;
    localparam logic [OP_W-1:0] OP_MULTU = 6'h07;
    localparam logic [OP_W-1:0] OP_DIV   = 6'h08;
    localparam logic [OP_W-1:0] OP_DIVU  = 6'h09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Registered shifter result as presented to the writeback path.
    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    value;
    } shift_res_t;

    // Ops that read or write HI/LO and therefore interlock against busy.
    function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        return (op >= OP_SRL) && (op <= OP_DIVU);
    endfunction

    // Two's-complement magnitude; -2^31 maps onto itself, read as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : v;
    endfunction

endpackage

// File: rtl/pipeline_latealu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// {acc[63:32], acc[31:0]} holds {HI, LO} for multiply and {remainder, quotient} for divide.
module pipeline_latealu_muldiv_iter
    import pipeline_latealu_pkg::*;
#(
    parameter int unsigned BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_div,
    input  logic                  run,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  last_c,
    output logic [2*DATA_W-1:0]   acc
);

    localparam int unsigned MUL_STEPS = DATA_W / BITS;
    localparam int unsigned SUM_W     = DATA_W + BITS;

    logic [2*DATA_W-1:0]  acc_q;
    logic [DATA_W-1:0]    opnd_q;
    logic                 div_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [BITS-1:0]          mul_digit;
    logic [SUM_W-1:0]         mul_partial;
    logic [SUM_W-1:0]         mul_sum;
    logic [2*DATA_W+BITS-1:0] mul_wide;
    logic [2*DATA_W-1:0]      mul_next;
    logic [DATA_W:0]          rem_shift;
    logic [DATA_W+1:0]        rem_diff;
    logic [2*DATA_W-1:0]      div_next;

    // One multiply step: add multiplicand * low digit into the upper half, then shift right.
    always_comb begin
        mul_digit   = acc_q[BITS-1:0];
        mul_partial = SUM_W'(opnd_q) * SUM_W'(mul_digit);
        mul_sum     = SUM_W'(acc_q[2*DATA_W-1:DATA_W]) + mul_partial;
        mul_wide    = {mul_sum, acc_q[DATA_W-1:0]};
        mul_next    = (2*DATA_W)'(mul_wide >> BITS);
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        rem_diff  = {1'b0, rem_shift} - {2'b00, opnd_q};
        if (!rem_diff[DATA_W+1]) begin
            div_next = {rem_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            div_next = {rem_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
    end

    assign last_c = run & (cnt_q == (div_q ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MUL_STEPS - 1)));
    assign acc    = acc_q;

    // Operand load on start, one step per cycle while the FSM keeps run high.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            acc_q  <= {{DATA_W{1'b0}}, (is_div ? op_a : op_b)};
            opnd_q <= is_div ? op_b : op_a;
            div_q  <= is_div;
            cnt_q  <= '0;
        end else if (run) begin
            acc_q  <= div_q ? div_next : mul_next;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_latealu.sv
// Late-stage ALU: shifts, HI/LO moves, iterative mult/div, HI/LO interlock.
module pipeline_latealu
    import pipeline_latealu_pkg::*;
#(
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  latealu_enable,
    input  logic [OP_W-1:0]       latealu_op,
    input  logic [DATA_W-1:0]     latealu_a0,
    input  logic [DATA_W-1:0]     latealu_a1,
    input  logic [REG_IDX_W-1:0]  rd_index_in,
    input  logic                  hilo_read_req,
    output logic                  stall,
    output logic                  busy,
    output logic [DATA_W-1:0]     latealu_mult_hi,
    output logic [DATA_W-1:0]     latealu_mult_lo,
    output logic                  shift_valid,
    output logic [REG_IDX_W-1:0]  shift_rd_index,
    output logic [DATA_W-1:0]     shift_value,
    output logic                  div_by_zero,
    output logic                  bad_op
);

    state_t               state_q, state_d;
    logic                 busy_q;
    logic [DATA_W-1:0]    hi_q, hi_d;
    logic [DATA_W-1:0]    lo_q, lo_d;
    logic                 neg_quo_q;
    logic                 neg_rem_q;
    logic                 fix_div_q;
    logic                 dbz_q;
    logic                 bad_op_q;
    shift_res_t           shift_q, shift_d;

    logic                 accept;
    logic                 op_shift, op_mult, op_div, op_signed, div_zero;
    logic                 start;
    logic                 run;
    logic                 iter_last_c;
    logic [2*DATA_W-1:0]  iter_acc;
    logic [DATA_W-1:0]    iter_a, iter_b;
    logic [2*DATA_W-1:0]  prod_fix;
    logic [DATA_W-1:0]    quo_fix, rem_fix;

    // Interlock: hold the ALU stage on any HI/LO access while an iterative op is in flight.
    assign stall  = busy_q & (hilo_read_req | (latealu_enable & is_hilo_op(latealu_op)));
    assign accept = latealu_enable & ~stall;

    // Op decode.
    always_comb begin
        op_shift  = (latealu_op == OP_SRL)  | (latealu_op == OP_SRA);
        op_mult   = (latealu_op == OP_MULT) | (latealu_op == OP_MULTU);
        op_div    = (latealu_op == OP_DIV)  | (latealu_op == OP_DIVU);
        op_signed = (latealu_op == OP_MULT) | (latealu_op == OP_DIV);
        div_zero  = op_div & (latealu_a1 == '0);
    end

    // Signed ops iterate on magnitudes; signs are restored in FIX.
    assign iter_a = op_signed ? abs_val(latealu_a0) : latealu_a0;
    assign iter_b = op_signed ? abs_val(latealu_a1) : latealu_a1;
    assign run    = (state_q == ST_MUL) | (state_q == ST_DIV);

    pipeline_latealu_muldiv_iter #(
        .BITS (MUL_BITS_PER_CYCLE)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .is_div (op_div),
        .run    (run),
        .op_a   (iter_a),
        .op_b   (iter_b),
        .last_c (iter_last_c),
        .acc    (iter_acc)
    );

    // Sign fixup of the unsigned iteration result.
    always_comb begin
        prod_fix = neg_quo_q ? (2*DATA_W)'(-iter_acc) : iter_acc;
        quo_fix  = neg_quo_q ? DATA_W'(-iter_acc[DATA_W-1:0]) : iter_acc[DATA_W-1:0];
        rem_fix  = neg_rem_q ? DATA_W'(-iter_acc[2*DATA_W-1:DATA_W]) : iter_acc[2*DATA_W-1:DATA_W];
    end

    // Next-state and HI/LO write selection.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (latealu_op == OP_MTHI) begin
                        hi_d = latealu_a0;
                    end else if (latealu_op == OP_MTLO) begin
                        lo_d = latealu_a0;
                    end else if (op_mult) begin
                        start   = 1'b1;
                        state_d = ST_MUL;
                    end else if (div_zero) begin
                        hi_d = latealu_a0;
                        lo_d = '1;
                    end else if (op_div) begin
                        start   = 1'b1;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (iter_last_c) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (fix_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*DATA_W-1:DATA_W];
                    lo_d = prod_fix[DATA_W-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, busy, HI/LO and latched result signs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fix_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (start) begin
                neg_quo_q <= op_signed & (latealu_a0[DATA_W-1] ^ latealu_a1[DATA_W-1]);
                neg_rem_q <= op_signed & latealu_a0[DATA_W-1];
                fix_div_q <= op_div;
            end
        end
    end

    // Shifter result for this cycle's accepted shift, if any.
    always_comb begin
        shift_d       = shift_q;
        shift_d.valid = 1'b0;
        if (accept && op_shift) begin
            shift_d.valid = 1'b1;
            shift_d.rd    = rd_index_in;
            if (latealu_op == OP_SRA) begin
                shift_d.value = DATA_W'($signed(latealu_a0) >>> latealu_a1[4:0]);
            end else begin
                shift_d.value = latealu_a0 >> latealu_a1[4:0];
            end
        end
    end

    // Registered shift result and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= '0;
            dbz_q    <= 1'b0;
            bad_op_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            dbz_q    <= accept & div_zero & (state_q == ST_IDLE);
            bad_op_q <= accept & ~is_known_op(latealu_op);
        end
    end

    assign busy            = busy_q;
    assign latealu_mult_hi = hi_q;
    assign latealu_mult_lo = lo_q;
    assign shift_valid     = shift_q.valid;
    assign shift_rd_index  = shift_q.rd;
    assign shift_value     = shift_q.value;
    assign div_by_zero     = dbz_q;
    assign bad_op          = bad_op_q;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Scoreboard bench for pipeline_latealu: stimulus pushes expected HI/LO and shift
// results, a negedge monitor pops them when the DUT presents a result.
module tb_pipeline_latealu;

    logic        clk;
    logic        rst;
    logic        latealu_enable;
    logic [5:0]  latealu_op;
    logic [31:0] latealu_a0;
    logic [31:0] latealu_a1;
    logic [4:0]  rd_index_in;
    logic        hilo_read_req;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        shift_valid;
    logic [4:0]  shift_rd_index;
    logic [31:0] shift_value;
    logic        div_by_zero;
    logic        bad_op;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_exp_t;

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [31:0] value;
    } shift_exp_t;

    hilo_exp_t  hilo_q[$];
    shift_exp_t shift_q[$];

    int checks = 0;
    int errors = 0;
    logic prev_busy = 1'b0;

    pipeline_latealu #(.MUL_BITS_PER_CYCLE(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .latealu_enable  (latealu_enable),
        .latealu_op      (latealu_op),
        .latealu_a0      (latealu_a0),
        .latealu_a1      (latealu_a1),
        .rd_index_in     (rd_index_in),
        .hilo_read_req   (hilo_read_req),
        .stall           (stall),
        .busy            (busy),
        .latealu_mult_hi (hi),
        .latealu_mult_lo (lo),
        .shift_valid     (shift_valid),
        .shift_rd_index  (shift_rd_index),
        .shift_value     (shift_value),
        .div_by_zero     (div_by_zero),
        .bad_op          (bad_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: HI/LO result on busy falling or div_by_zero pulse; shift result on shift_valid.
    always @(negedge clk) begin
        hilo_exp_t  e;
        shift_exp_t s;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if ((prev_busy && !busy) || div_by_zero) begin
                if (hilo_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hilo_unexpected: got hi=%h lo=%h with no pending result", hi, lo);
                end else begin
                    e = hilo_q.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                end
            end
            if (shift_valid) begin
                if (shift_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL shift_unexpected: got value=%h rd=%0d", shift_value, shift_rd_index);
                end else begin
                    s = shift_q.pop_front();
                    check({s.name, "_value"}, shift_value, s.value);
                    check({s.name, "_rd"}, 32'(shift_rd_index), 32'(s.rd));
                end
            end
            prev_busy = busy;
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [4:0] rd);
        latealu_enable = 1'b1;
        latealu_op     = op;
        latealu_a0     = a0;
        latealu_a1     = a1;
        rd_index_in    = rd;
        @(posedge clk);
        #1;
        latealu_enable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        latealu_enable = 1'b0;
        latealu_op     = '0;
        latealu_a0     = '0;
        latealu_a1     = '0;
        rd_index_in    = '0;
        hilo_read_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_shift_valid", 32'(shift_valid), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        check("rst_bad_op", 32'(bad_op), 0);

        // 1: signed mult 7 * -3, busy for K+1 = 33 cycles
        hilo_q.push_back('{"mult_7_m3", 32'hFFFFFFFF, 32'hFFFFFFEB});
        issue(6'h04, 32'd7, 32'hFFFFFFFD, 5'd0);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("mult_busy_cycles", 32'(n), 33);

        // 2: multu with mfhi held from 4 cycles after accept; stall until busy falls
        hilo_q.push_back('{"multu_max", 32'hFFFFFFFE, 32'h00000001});
        issue(6'h07, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        repeat (4) @(posedge clk);
        #1 hilo_read_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (stall && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("mfhi_stall_cycles", 32'(n), 29);
        check("mfhi_busy_after", 32'(busy), 0);
        check("mfhi_hi_value", hi, 32'hFFFFFFFE);
        hilo_read_req = 1'b0;

        // 3: divides
        hilo_q.push_back('{"divu_100_7", 32'd2, 32'd14});
        issue(6'h09, 32'd100, 32'd7, 5'd0);
        wait_idle("divu_100_7");
        hilo_q.push_back('{"div_m7_2", 32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(6'h08, 32'hFFFFFFF9, 32'd2, 5'd0);
        wait_idle("div_m7_2");
        hilo_q.push_back('{"div_ovf", 32'h00000000, 32'h80000000});
        issue(6'h08, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        wait_idle("div_ovf");

        // 4: divide by zero
        hilo_q.push_back('{"div_by0", 32'd5, 32'hFFFFFFFF});
        issue(6'h08, 32'd5, 32'd0, 5'd0);
        @(negedge clk);
        check("dbz_pulse", 32'(div_by_zero), 1);
        check("dbz_busy", 32'(busy), 0);
        @(negedge clk);
        check("dbz_pulse_end", 32'(div_by_zero), 0);
        check("dbz_busy_after", 32'(busy), 0);

        // 5: shifts accepted while busy, mtlo stalled
        hilo_q.push_back('{"divu_busy", 32'd0, 32'd100});
        issue(6'h09, 32'd1000, 32'd10, 5'd0);
        shift_q.push_back('{"srl_31", 5'd9, 32'h00000001});
        issue(6'h02, 32'h80000000, 32'd31, 5'd9);
        shift_q.push_back('{"sra_4", 5'd3, 32'hF8000000});
        issue(6'h03, 32'h80000000, 32'd4, 5'd3);
        latealu_enable = 1'b1;
        latealu_op     = 6'h06;
        latealu_a0     = 32'hDEADBEEF;
        @(negedge clk);
        check("mtlo_busy_stall", 32'(stall), 1);
        @(posedge clk);
        #1 latealu_enable = 1'b0;
        wait_idle("divu_busy");

        // mthi / mtlo when idle, readable next cycle
        issue(6'h05, 32'h00005678, 32'd0, 5'd0);
        issue(6'h06, 32'h00001234, 32'd0, 5'd0);
        @(negedge clk);
        check("mthi_value", hi, 32'h00005678);
        check("mtlo_value", lo, 32'h00001234);

        // Unknown op
        issue(6'h3F, 32'd1, 32'd1, 5'd1);
        @(negedge clk);
        check("bad_op_pulse", 32'(bad_op), 1);
        check("bad_op_no_shift", 32'(shift_valid), 0);
        @(negedge clk);
        check("bad_op_pulse_end", 32'(bad_op), 0);

        // 6: reset at iteration 10 of a mult aborts it; new mult then completes
        issue(6'h04, 32'd3, 32'd5, 5'd0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        hilo_q.push_back('{"mult_after_rst", 32'hFFFFFFFF, 32'hDB975310});
        issue(6'h04, 32'h12345678, 32'hFFFFFFFE, 5'd0);
        wait_idle("mult_after_rst");

        repeat (2) @(negedge clk);
        check("hilo_queue_empty", 32'(hilo_q.size()), 0);
        check("shift_queue_empty", 32'(shift_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
